// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-master Wishbone memory arbiter: FSM states and one-hot grant codes.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrantM0,
    StGrantM1
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  function automatic logic [1:0] state_to_grant(arb_state_e state);
    logic [1:0] grant;
    case (state)
      StGrantM0: grant = GRANT_M0;
      StGrantM1: grant = GRANT_M1;
      default:   grant = GRANT_NONE;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/memory_arbiter_mux.sv
// Combinational 2:1 Wishbone request mux and response demux steered by a one-hot grant.
module wb_master_mux
  import memory_arbiter_pkg::*;
(
  input  logic [1:0]  grant_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_stall_o,
  output logic        m1_ack_o,
  output logic        m1_stall_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i
);

  always_comb begin
    // Idle drives m0's request fields so the slave bus never floats.
    wb_adr_o   = m0_adr_i;
    wb_dat_o   = m0_dat_i;
    wb_we_o    = m0_we_i;
    wb_sel_o   = m0_sel_i;
    wb_stb_o   = 1'b0;
    wb_cyc_o   = 1'b0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_stall_o = 1'b1;
    unique case (grant_i)
      GRANT_M0: begin
        wb_stb_o   = m0_stb_i;
        wb_cyc_o   = m0_cyc_i;
        m0_ack_o   = wb_ack_i & m0_cyc_i;
        m0_stall_o = wb_stall_i;
      end
      GRANT_M1: begin
        wb_adr_o   = m1_adr_i;
        wb_dat_o   = m1_dat_i;
        wb_we_o    = m1_we_i;
        wb_sel_o   = m1_sel_i;
        wb_stb_o   = m1_stb_i;
        wb_cyc_o   = m1_cyc_i;
        m1_ack_o   = wb_ack_i & m1_cyc_i;
        m1_stall_o = wb_stall_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one pipelined Wishbone port between fetch (m0) and load/store (m1), granting whole cycles.
// Define ARBITER_ROUND_ROBIN_EN to replace fixed m1 > m0 priority with last-owner round robin.
module memory_arbiter
  import memory_arbiter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic        m0_wb_we_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_stall_o,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  input  logic        m1_wb_we_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_stall_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i,
  output logic [1:0]  grant_o
);

  arb_state_e state_q, state_d;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_m1_q, last_m1_d;  // 1: m1 was granted most recently

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_m1_q <= 1'b0;
    end else begin
      last_m1_q <= last_m1_d;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
`ifdef ARBITER_ROUND_ROBIN_EN
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          state_d = last_m1_q ? StGrantM0 : StGrantM1;
        end else
`endif
        if (m1_wb_cyc_i) begin
          state_d = StGrantM1;
        end else if (m0_wb_cyc_i) begin
          state_d = StGrantM0;
        end
      end
      // Handover goes straight to the waiting master without an idle cycle.
      StGrantM0: if (!m0_wb_cyc_i) state_d = m1_wb_cyc_i ? StGrantM1 : StIdle;
      StGrantM1: if (!m1_wb_cyc_i) state_d = m0_wb_cyc_i ? StGrantM0 : StIdle;
      default:   state_d = StIdle;
    endcase
  end

`ifdef ARBITER_ROUND_ROBIN_EN
  always_comb begin
    last_m1_d = last_m1_q;
    if (state_d != StIdle) last_m1_d = (state_d == StGrantM1);
  end
`endif

  logic [31:0] mux_adr, mux_dat;
  logic [3:0]  mux_sel;
  logic        mux_we;

  // state_q is already idle during reset, so only the idle pass-through fields need masking.
  assign grant_o     = state_to_grant(state_q);
  assign wb_adr_o    = rst_ni ? mux_adr : '0;
  assign wb_dat_o    = rst_ni ? mux_dat : '0;
  assign wb_sel_o    = rst_ni ? mux_sel : '0;
  assign wb_we_o     = rst_ni & mux_we;
  assign m0_wb_dat_o = wb_dat_i;
  assign m1_wb_dat_o = wb_dat_i;

  wb_master_mux u_mux (
    .grant_i    (grant_o),
    .m0_adr_i   (m0_wb_adr_i),
    .m0_dat_i   (m0_wb_dat_i),
    .m0_we_i    (m0_wb_we_i),
    .m0_sel_i   (m0_wb_sel_i),
    .m0_stb_i   (m0_wb_stb_i),
    .m0_cyc_i   (m0_wb_cyc_i),
    .m1_adr_i   (m1_wb_adr_i),
    .m1_dat_i   (m1_wb_dat_i),
    .m1_we_i    (m1_wb_we_i),
    .m1_sel_i   (m1_wb_sel_i),
    .m1_stb_i   (m1_wb_stb_i),
    .m1_cyc_i   (m1_wb_cyc_i),
    .m0_ack_o   (m0_wb_ack_o),
    .m0_stall_o (m0_wb_stall_o),
    .m1_ack_o   (m1_wb_ack_o),
    .m1_stall_o (m1_wb_stall_o),
    .wb_adr_o   (mux_adr),
    .wb_dat_o   (mux_dat),
    .wb_we_o    (mux_we),
    .wb_sel_o   (mux_sel),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i),
    .wb_stall_i (wb_stall_i)
  );

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_memory_arbiter;

`ifdef ARBITER_ROUND_ROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] m0_adr = '0, m0_dat = '0, m1_adr = '0, m1_dat = '0;
  logic        m0_we = 1'b0, m0_stb = 1'b0, m0_cyc = 1'b0;
  logic        m1_we = 1'b0, m1_stb = 1'b0, m1_cyc = 1'b0;
  logic [3:0]  m0_sel = '0, m1_sel = '0;
  logic [31:0] m0_rdat, m1_rdat, wb_adr, wb_wdat, wb_rdat = '0;
  logic        m0_ack, m0_stall, m1_ack, m1_stall;
  logic        wb_we, wb_stb, wb_cyc, wb_ack = 1'b0, wb_stall = 1'b0;
  logic [3:0]  wb_sel;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: owner 0 = none, 1 = m0, 2 = m1.
  int owner_q;
  bit last_m1_q;

  always #5 clk_i = ~clk_i;

  memory_arbiter dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .m0_wb_adr_i   (m0_adr),
    .m0_wb_dat_i   (m0_dat),
    .m0_wb_we_i    (m0_we),
    .m0_wb_sel_i   (m0_sel),
    .m0_wb_stb_i   (m0_stb),
    .m0_wb_cyc_i   (m0_cyc),
    .m0_wb_dat_o   (m0_rdat),
    .m0_wb_ack_o   (m0_ack),
    .m0_wb_stall_o (m0_stall),
    .m1_wb_adr_i   (m1_adr),
    .m1_wb_dat_i   (m1_dat),
    .m1_wb_we_i    (m1_we),
    .m1_wb_sel_i   (m1_sel),
    .m1_wb_stb_i   (m1_stb),
    .m1_wb_cyc_i   (m1_cyc),
    .m1_wb_dat_o   (m1_rdat),
    .m1_wb_ack_o   (m1_ack),
    .m1_wb_stall_o (m1_stall),
    .wb_adr_o      (wb_adr),
    .wb_dat_o      (wb_wdat),
    .wb_we_o       (wb_we),
    .wb_sel_o      (wb_sel),
    .wb_stb_o      (wb_stb),
    .wb_cyc_o      (wb_cyc),
    .wb_dat_i      (wb_rdat),
    .wb_ack_i      (wb_ack),
    .wb_stall_i    (wb_stall),
    .grant_o       (grant)
  );

  // An open cycle is never preempted; otherwise any requester wins, ties broken by policy.
  function automatic int next_owner(int owner, bit c0, bit c1, bit last_m1);
    if (owner == 1 && c0) return 1;
    if (owner == 2 && c1) return 2;
    if (c0 && c1) return (RrEn && last_m1) ? 1 : 2;
    if (c1) return 2;
    if (c0) return 1;
    return 0;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    int n;
    if (!rst_ni) begin
      owner_q   <= 0;
      last_m1_q <= 1'b0;
    end else begin
      n = next_owner(owner_q, m0_cyc, m1_cyc, last_m1_q);
      owner_q <= n;
      if (n != 0) last_m1_q <= (n == 2);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0]  e_grant;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic        e_we, e_cyc, e_stb;
    e_grant = (owner_q == 1) ? 2'b01 : (owner_q == 2) ? 2'b10 : 2'b00;
    e_adr   = (owner_q == 2) ? m1_adr : m0_adr;
    e_dat   = (owner_q == 2) ? m1_dat : m0_dat;
    e_sel   = (owner_q == 2) ? m1_sel : m0_sel;
    e_we    = (owner_q == 2) ? m1_we : m0_we;
    e_cyc   = (owner_q == 1) ? m0_cyc : (owner_q == 2) ? m1_cyc : 1'b0;
    e_stb   = (owner_q == 1) ? m0_stb : (owner_q == 2) ? m1_stb : 1'b0;
    if (!rst_ni) begin
      e_adr = '0;
      e_dat = '0;
      e_sel = '0;
      e_we  = 1'b0;
    end
    check_eq({tag, ".grant"}, 32'(grant), 32'(e_grant));
    check_eq({tag, ".cyc"}, 32'(wb_cyc), 32'(e_cyc));
    check_eq({tag, ".stb"}, 32'(wb_stb), 32'(e_stb));
    check_eq({tag, ".adr"}, wb_adr, e_adr);
    check_eq({tag, ".wdat"}, wb_wdat, e_dat);
    check_eq({tag, ".sel"}, 32'(wb_sel), 32'(e_sel));
    check_eq({tag, ".we"}, 32'(wb_we), 32'(e_we));
    check_eq({tag, ".m0_ack"}, 32'(m0_ack), 32'(owner_q == 1 && m0_cyc && wb_ack));
    check_eq({tag, ".m1_ack"}, 32'(m1_ack), 32'(owner_q == 2 && m1_cyc && wb_ack));
    check_eq({tag, ".m0_stall"}, 32'(m0_stall), 32'((owner_q == 1) ? wb_stall : 1'b1));
    check_eq({tag, ".m1_stall"}, 32'(m1_stall), 32'((owner_q == 2) ? wb_stall : 1'b1));
    check_eq({tag, ".m0_rdat"}, m0_rdat, wb_rdat);
    check_eq({tag, ".m1_rdat"}, m1_rdat, wb_rdat);
  endtask

  // Check at the falling edge, then advance to just after the next rising edge.
  task automatic step(input string tag);
    @(negedge clk_i);
    check_all(tag);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset with a nonzero m0 address to show the idle pass-through is masked.
    m0_adr = 32'hA5A5_0001;
    m0_sel = 4'hF;
    @(negedge clk_i);
    check_all("rst");
    check_eq("rst.adr_zero", wb_adr, 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    m0_adr = '0;
    m0_sel = '0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check_eq("idle.grant", 32'(grant), 32'h0);
      check_eq("idle.cyc", 32'(wb_cyc), 32'h0);
      check_eq("idle.stalls", 32'({m1_stall, m0_stall}), 32'h3);
      @(posedge clk_i);
      #1;
    end

    // m0 single read.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_1000; m0_sel = 4'hF;
    @(negedge clk_i);
    check_eq("m0rd.grant_not_yet", 32'(grant), 32'h0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("m0rd.grant", 32'(grant), 32'h1);
    check_eq("m0rd.stb", 32'(wb_stb), 32'h1);
    check_eq("m0rd.adr", wb_adr, 32'h0000_1000);
    @(posedge clk_i); #1;
    m0_stb = 1'b0;
    step("m0rd.wait");
    wb_ack = 1'b1; wb_rdat = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check_eq("m0rd.ack", 32'(m0_ack), 32'h1);
    check_eq("m0rd.m1_ack", 32'(m1_ack), 32'h0);
    check_eq("m0rd.rdat", m0_rdat, 32'hDEAD_BEEF);
    @(posedge clk_i); #1;
    wb_ack = 1'b0; m0_cyc = 1'b0;
    step("m0rd.drop");
    step("m0rd.idle");

    // Simultaneous requests, then handover with no idle cycle.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_2000;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_3000;
    step("both.req");
    @(negedge clk_i);
    check_eq("both.grant_m1", 32'(grant), 32'h2);
    check_eq("both.m0_stalled", 32'(m0_stall), 32'h1);
    @(posedge clk_i); #1;
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step("both.m1_drop");
    @(negedge clk_i);
    check_eq("both.handover", 32'(grant), 32'h1);
    @(posedge clk_i); #1;
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step("both.m0_drop");
    step("both.idle");

    // m1 write held under slave stall.
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    m1_adr = 32'h0000_4000; m1_dat = 32'h1234_5678; m1_sel = 4'b0011;
    wb_stall = 1'b1;
    step("wr.req");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq("wr.stb_held", 32'(wb_stb), 32'h1);
      check_eq("wr.dat_held", wb_wdat, 32'h1234_5678);
      check_eq("wr.sel_held", 32'(wb_sel), 32'h3);
      check_eq("wr.stall_mirror", 32'(m1_stall), 32'h1);
      @(posedge clk_i); #1;
    end
    wb_stall = 1'b0;
    @(negedge clk_i);
    check_eq("wr.stall_release", 32'(m1_stall), 32'h0);
    @(posedge clk_i); #1;
    m1_stb = 1'b0; wb_ack = 1'b1;
    @(negedge clk_i);
    check_eq("wr.ack", 32'(m1_ack), 32'h1);
    check_eq("wr.m0_ack", 32'(m0_ack), 32'h0);
    @(posedge clk_i); #1;
    wb_ack = 1'b0;
    step("wr.ack_done");

    // Asynchronous reset while m1 holds the bus.
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("arst.grant", 32'(grant), 32'h0);
    check_eq("arst.cyc", 32'(wb_cyc), 32'h0);
    check_eq("arst.stb", 32'(wb_stb), 32'h0);
    check_all("arst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1; m1_cyc = 1'b0; m1_we = 1'b0;
    step("arst.release");

    // Randomized traffic; cyc toggles occasionally so cycles span several beats.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(3) == 0) m1_cyc = ~m1_cyc;
      m0_stb   = m0_cyc & 1'($urandom);
      m1_stb   = m1_cyc & 1'($urandom);
      m0_adr   = $urandom;
      m1_adr   = $urandom;
      m0_dat   = $urandom;
      m1_dat   = $urandom;
      m0_sel   = 4'($urandom);
      m1_sel   = 4'($urandom);
      m0_we    = 1'($urandom);
      m1_we    = 1'($urandom);
      wb_ack   = 1'($urandom);
      wb_stall = 1'($urandom);
      wb_rdat  = $urandom;
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
